// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants: modulus, GAMMA2 choices, max high-part quotients
// and security-level encodings.
package dilithium_pkg;

  localparam int unsigned Q         = 8380417;
  localparam int unsigned GAMMA2_88 = 95232;
  localparam int unsigned GAMMA2_32 = 261888;
  localparam int          QMAX_88   = 44;
  localparam int          QMAX_32   = 16;

  typedef enum logic [2:0] {
    SEC_LVL_0 = 3'd0,
    SEC_LVL_2 = 3'd2,
    SEC_LVL_3 = 3'd3,
    SEC_LVL_5 = 3'd5
  } sec_lvl_e;

endpackage

// File: rtl/decomp_map1_core.sv
// Combinational Decompose high-part mapping; optional low part with
// DECOMP_MAP1_R0_EN defined.
module decomp_map1_core
  import dilithium_pkg::GAMMA2_88;
  import dilithium_pkg::GAMMA2_32;
  import dilithium_pkg::QMAX_88;
  import dilithium_pkg::QMAX_32;
  import dilithium_pkg::SEC_LVL_2;
#(
  parameter int unsigned Q = dilithium_pkg::Q
) (
  input  logic [2:0]  sec_lvl,
  input  logic [22:0] din,
  output logic [5:0]  dout
`ifdef DECOMP_MAP1_R0_EN
  ,
  output logic [22:0] r0
`endif
);

  logic [5:0] q88;
  logic [5:0] q32;
  logic [5:0] raw;
  logic [5:0] qmax;
  logic       sel88;
  logic       wrap;
  logic       over;

  // Raw quotient floor((din+G-1)/2G) equals the number of thresholds
  // (2k-1)*G+1 that din reaches, so it is a sum of constant compares.
  always_comb begin
    q88 = '0;
    for (int k = 1; k <= QMAX_88; k++) begin
      if (32'(din) >= 32'((2 * k - 1) * GAMMA2_88 + 1)) q88 = q88 + 6'd1;
    end
    q32 = '0;
    for (int k = 1; k <= QMAX_32; k++) begin
      if (32'(din) >= 32'((2 * k - 1) * GAMMA2_32 + 1)) q32 = q32 + 6'd1;
    end
    sel88 = (sec_lvl == SEC_LVL_2);
    raw   = sel88 ? q88 : q32;
    qmax  = sel88 ? 6'(QMAX_88) : 6'(QMAX_32);
    wrap  = (raw == qmax);
    over  = (32'(din) >= Q);
    dout  = (over || wrap) ? 6'd0 : raw;
  end

`ifdef DECOMP_MAP1_R0_EN
  logic [22:0] two_g;
  logic [22:0] prod;

  // The low part always fits in 23 bits, so modular 23-bit arithmetic
  // yields the exact two's complement value.
  always_comb begin
    two_g = sel88 ? 23'(2 * GAMMA2_88) : 23'(2 * GAMMA2_32);
    prod  = 23'(raw) * two_g;
    r0    = over ? 23'd0 : (din - prod - 23'(wrap));
  end
`endif

endmodule

// File: rtl/decomp_map1.sv
// Registered Decompose high-part stage with a one-cycle valid pipeline.
// Optional low-part output r0 is enabled by defining DECOMP_MAP1_R0_EN.
module decomp_map1 #(
  parameter int unsigned Q = dilithium_pkg::Q
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [2:0]  sec_lvl,
  input  logic [22:0] din,
  output logic        out_valid,
  output logic [5:0]  dout
`ifdef DECOMP_MAP1_R0_EN
  ,
  output logic [22:0] r0
`endif
);

  logic [5:0] dout_c;
`ifdef DECOMP_MAP1_R0_EN
  logic [22:0] r0_c;
`endif

  decomp_map1_core #(.Q(Q)) u_core (
    .sec_lvl (sec_lvl),
    .din     (din),
    .dout    (dout_c)
`ifdef DECOMP_MAP1_R0_EN
    ,
    .r0      (r0_c)
`endif
  );

  // Results load only on valid input and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
`ifdef DECOMP_MAP1_R0_EN
      r0        <= '0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        dout <= dout_c;
`ifdef DECOMP_MAP1_R0_EN
        r0   <= r0_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_decomp_map1.sv
// Self-checking bench for decomp_map1: directed table, wrap sweep, hold,
// asynchronous reset and randomized inputs against an arithmetic model.
module tb_decomp_map1;

  localparam int QV = 8380417;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [2:0]  sec_lvl;
  logic [22:0] din;
  logic        out_valid;
  logic [5:0]  dout;
`ifdef DECOMP_MAP1_R0_EN
  logic [22:0] r0;
`endif

  int checks;
  int failures;

  decomp_map1 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sec_lvl   (sec_lvl),
    .din       (din),
    .out_valid (out_valid),
    .dout      (dout)
`ifdef DECOMP_MAP1_R0_EN
    ,
    .r0        (r0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sec;
    int d;
    int exp_dout;
    int exp_r0;
  } vec_t;

  vec_t vecs[$];

  // Model straight from the Decompose definition.
  function automatic void model(input int sec, input int d, output int md, output int mr);
    int g;
    int raw;
    g = (sec == 2) ? (QV - 1) / 88 : (QV - 1) / 32;
    if (d >= QV) begin
      md = 0;
      mr = 0;
    end else begin
      raw = (d + g - 1) / (2 * g);
      if (raw == (QV - 1) / (2 * g)) begin
        md = 0;
        mr = d - raw * 2 * g - 1;
      end else begin
        md = raw;
        mr = d - raw * 2 * g;
      end
    end
  endfunction

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0b required=%0b", name, act, req);
    end
  endtask

  task automatic check_output(input string name, input int exp_dout, input int exp_r0);
    logic [5:0]  ed;
    logic [22:0] er;
    ed = 6'(exp_dout);
    er = 23'(exp_r0);
    check_bit({name, ".out_valid"}, out_valid, 1'b1);
    checks++;
    if (dout !== ed) begin
      failures++;
      $display("[TB] FAIL %s.dout: actual=%0d required=%0d", name, dout, ed);
    end
`ifdef DECOMP_MAP1_R0_EN
    checks++;
    if (r0 !== er) begin
      failures++;
      $display("[TB] FAIL %s.r0: actual=%0d required=%0d", name, $signed(r0), $signed(er));
    end
`else
    if (er != er) $display("[TB] unreachable");
`endif
  endtask

  // Drive one valid sample and advance to just after the capturing edge.
  task automatic apply_stimulus(input int sec, input int d);
    in_valid = 1'b1;
    sec_lvl  = 3'(sec);
    din      = 23'(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int md;
    int mr;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    sec_lvl  = 3'd0;
    din      = '0;

    #3;
    check_bit("reset.out_valid", out_valid, 1'b0);
    checks++;
    if (dout !== 6'd0) begin
      failures++;
      $display("[TB] FAIL reset.dout: actual=%0d required=0", dout);
    end
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{3, 261889, 1, -261887});
    vecs.push_back('{0, 261888, 0, 261888});
    vecs.push_back('{0, 261889, 1, -261887});
    vecs.push_back('{0, 7594753, 15, -261887});
    vecs.push_back('{0, 8118529, 0, -261888});
    vecs.push_back('{2, 95232, 0, 95232});
    vecs.push_back('{2, 95233, 1, -95231});
    vecs.push_back('{2, 8094721, 43, -95231});
    vecs.push_back('{2, 8285185, 0, -95232});
    vecs.push_back('{2, 8380416, 0, -1});
    vecs.push_back('{0, 8380416, 0, -1});
    vecs.push_back('{5, 0, 0, 0});
    vecs.push_back('{5, 8380417, 0, 0});
    vecs.push_back('{2, 8380417, 0, 0});
    vecs.push_back('{7, 8388607, 0, 0});

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].sec, vecs[i].d);
      check_output($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_r0);
    end

    for (int k = 0; k <= 43; k++) begin
      apply_stimulus(2, 95233 + k * 190464);
      check_output($sformatf("sweep%0d", k), (k < 43) ? k + 1 : 0,
                   (k < 43) ? -95231 : -95232);
    end

    apply_stimulus(0, 7594753);
    check_output("hold.pre", 15, -261887);
    in_valid = 1'b0;
    din      = 23'd5;
    @(posedge clk);
    #1;
    check_bit("hold.out_valid", out_valid, 1'b0);
    checks++;
    if (dout !== 6'd15) begin
      failures++;
      $display("[TB] FAIL hold.dout: actual=%0d required=15", dout);
    end

    for (int n = 0; n < 300; n++) begin
      int s;
      int d;
      s = int'($urandom_range(0, 7));
      d = (n % 4 == 0) ? int'($urandom_range(8380000, 8388607)) : int'($urandom_range(0, QV - 1));
      model(s, d, md, mr);
      apply_stimulus(s, d);
      check_output($sformatf("rand%0d", n), md, mr);
    end

    apply_stimulus(3, 2000000);
    model(3, 2000000, md, mr);
    check_output("prereset", md, mr);
    #2;
    rst = 1'b1;
    #1;
    check_bit("midreset.out_valid", out_valid, 1'b0);
    checks++;
    if (dout !== 6'd0) begin
      failures++;
      $display("[TB] FAIL midreset.dout: actual=%0d required=0", dout);
    end
`ifdef DECOMP_MAP1_R0_EN
    checks++;
    if (r0 !== 23'd0) begin
      failures++;
      $display("[TB] FAIL midreset.r0: actual=%0d required=0", $signed(r0));
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(2, 95233);
    check_output("postreset", 1, -95231);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
